// File: rtl/beatmap_note_scheduler_if.sv
// rtl/beatmap_note_scheduler_if.sv - note handshake between the scheduler and the renderer/hit-judge
// Signals:
//   note_valid  head note available (master -> slave)
//   note_ready  consumer accepts head note (slave -> master)
//   note_lane   lane of head note
//   note_x      raw generator value of head note
//   note_idx    index of head note since start, wraps 255->0
interface beatmap_note_scheduler_if;
  logic       note_valid;
  logic       note_ready;
  logic [2:0] note_lane;
  logic [7:0] note_x;
  logic [7:0] note_idx;

  modport master (
    output note_valid,
    output note_lane,
    output note_x,
    output note_idx,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_lane,
    input  note_x,
    input  note_idx,
    output note_ready
  );
endinterface

// File: rtl/beatmap_note_scheduler.sv
// rtl/beatmap_note_scheduler.sv - samples the note stream once per beat tick, validates it and queues lanes for output
// Optional feature macro: BEAT_DEDUP_EN (discard a valid sample repeating the last pushed lane)
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   data_en, data       generator qualifier and 8-bit note value
//   start, stop         single-cycle pulses: begin a song / end sampling and drain
//   note (master)       note_valid/note_ready handshake carrying note_lane, note_x, note_idx
//   fifo_count          current queue occupancy (ADDR_W+1 bits)
//   overflow, bad_data  sticky error flags, cleared on start
//   state               00 IDLE, 01 PRIME, 10 RUN, 11 DRAIN
module beatmap_note_scheduler #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int PRELOAD    = 4,
  parameter int BASE       = 160,
  parameter int STEP_SHIFT = 2,
  parameter int LANES      = 5,
  parameter int TICK_DIV   = 12500000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     data_en,
  input  logic [7:0]               data,
  input  logic                     start,
  input  logic                     stop,
  beatmap_note_scheduler_if.master note,
  output logic [ADDR_W:0]          fifo_count,
  output logic                     overflow,
  output logic                     bad_data,
  output logic [1:0]               state
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = ADDR_W + 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]    PRELOAD_C = CW'(PRELOAD);
  localparam logic [7:0]       BASE_C    = 8'(BASE);
  localparam logic [7:0]       STEP_MASK = 8'((1 << STEP_SHIFT) - 1);
  localparam logic [7:0]       LANES_C   = 8'(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_RUN   = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        idx_q, idx_d;
  logic              overflow_q, overflow_d;
  logic              bad_q, bad_d;
  logic [2:0]        lane_mem_q [DEPTH];
  logic [2:0]        lane_mem_d [DEPTH];
  logic [7:0]        x_mem_q [DEPTH];
  logic [7:0]        x_mem_d [DEPTH];

  logic       tick, sample, in_range, dup, full, push, pop, start_go, valid_out;
  logic [7:0] d_off, lane_full;
  logic [2:0] lane;

  // Counter is parked at 0 in IDLE, so the first tick lands TICK_DIV cycles into PRIME.
  assign tick = (state_q != S_IDLE) && (cnt_q == TICK_LAST);

  // stop suppresses the coincident sample so nothing enters the queue once draining begins.
  assign sample = tick && data_en && !stop && ((state_q == S_PRIME) || (state_q == S_RUN));

  assign d_off     = data - BASE_C;
  assign lane_full = d_off >> STEP_SHIFT;
  assign lane      = lane_full[2:0];
  assign in_range  = (data >= BASE_C) && ((d_off & STEP_MASK) == 8'd0) && (lane_full < LANES_C);

  // Fullness is judged on the registered count, before any same-cycle pop.
  assign full      = (count_q == DEPTH_C);
  assign push      = sample && in_range && !dup && !full;
  assign valid_out = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (count_q != '0);
  assign pop       = valid_out && note.note_ready;
  assign start_go  = (state_q == S_IDLE) && start;

`ifdef BEAT_DEDUP_EN
  logic [2:0] last_lane_q, last_lane_d;
  logic       last_vld_q, last_vld_d;

  assign dup = last_vld_q && (last_lane_q == lane);

  always_comb begin
    last_lane_d = last_lane_q;
    last_vld_d  = last_vld_q;
    if (start_go) begin
      last_lane_d = '0;
      last_vld_d  = 1'b0;
    end else if (push) begin
      last_lane_d = lane;
      last_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_lane_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      last_lane_q <= last_lane_d;
      last_vld_q  <= last_vld_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // State register and datapath flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        lane_mem_q[i] <= '0;
        x_mem_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
      lane_mem_q <= lane_mem_d;
      x_mem_q    <= x_mem_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRIME;
      S_PRIME: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else if (push && ((count_q + 1'b1) >= PRELOAD_C)) begin
          state_d = S_RUN;
        end
      end
      S_RUN:   if (stop) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    bad_d      = bad_q;
    lane_mem_d = lane_mem_q;
    x_mem_d    = x_mem_q;

    if ((state_q == S_IDLE) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (start_go) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
      bad_d      = 1'b0;
    end else begin
      if (push) begin
        lane_mem_d[wr_ptr_q] = lane;
        x_mem_d[wr_ptr_q]    = data;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        idx_d    = idx_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (sample && !in_range) bad_d = 1'b1;
      if (sample && in_range && !dup && full) overflow_d = 1'b1;
    end
  end

  // Outputs; head fields read as zero while the queue is empty
  always_comb begin
    note.note_valid = valid_out;
    note.note_lane  = '0;
    note.note_x     = '0;
    if (count_q != '0) begin
      note.note_lane = lane_mem_q[rd_ptr_q];
      note.note_x    = x_mem_q[rd_ptr_q];
    end
    note.note_idx = idx_q;
    fifo_count    = count_q;
    overflow      = overflow_q;
    bad_data      = bad_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_beatmap_note_scheduler.sv
// tb/tb_beatmap_note_scheduler.sv - directed self-checking bench for beatmap_note_scheduler
module tb_beatmap_note_scheduler;

  logic       clk;
  logic       resetn;
  logic       data_en;
  logic [7:0] data;
  logic       start;
  logic       stop;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       bad_data;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_idx;

  beatmap_note_scheduler_if nif ();

  beatmap_note_scheduler #(
    .DEPTH      (4),
    .ADDR_W     (2),
    .PRELOAD    (2),
    .BASE       (160),
    .STEP_SHIFT (2),
    .LANES      (5),
    .TICK_DIV   (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_en    (data_en),
    .data       (data),
    .start      (start),
    .stop       (stop),
    .note       (nif),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .bad_data   (bad_data),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick_with(input logic [7:0] v);
    data = v;
    step(4);
  endtask

  task automatic to_idle();
    data_en        = 1'b0;
    nif.note_ready = 1'b1;
    stop           = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'b00) break;
      step();
    end
    check("to_idle", 32'(state), 32'd0);
    nif.note_ready = 1'b0;
  endtask

  task automatic probe(input logic [7:0] v, input logic exp_bad, input logic [2:0] exp_cnt);
    do_start();
    data_en = 1'b1;
    tick_with(v);
    check($sformatf("probe%0d_bad", v), 32'(bad_data), 32'(exp_bad));
    check($sformatf("probe%0d_cnt", v), 32'(fifo_count), 32'(exp_cnt));
    to_idle();
  endtask

  task automatic pop_check();
    if (exp_q.size() == 0) begin
      check("sb_underrun", 32'd1, 32'd0);
    end else begin
      check("sb_x", 32'(nif.note_x), 32'(exp_q[0]));
      check("sb_idx", 32'(nif.note_idx), 32'(exp_idx));
      void'(exp_q.pop_front());
      exp_idx = exp_idx + 8'd1;
    end
  endtask

  initial begin
    resetn         = 1'b0;
    data_en        = 1'b0;
    data           = 8'd0;
    start          = 1'b0;
    stop           = 1'b0;
    nif.note_ready = 1'b0;
    step(3);
    resetn = 1'b1;
    step();

    // Reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(nif.note_valid), 32'd0);
    check("rst_lane", 32'(nif.note_lane), 32'd0);
    check("rst_x", 32'(nif.note_x), 32'd0);
    check("rst_idx", 32'(nif.note_idx), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bad", 32'(bad_data), 32'd0);

    // 1: basic preload, run, output order and 1-cycle latency
    data_en = 1'b1;
    data    = 8'd160;
    do_start();
    check("t1_prime", 32'(state), 32'd1);
    step(3);
    check("t1_pretick_cnt", 32'(fifo_count), 32'd0);
    step();
    check("t1_cnt1", 32'(fifo_count), 32'd1);
    check("t1_still_prime", 32'(state), 32'd1);
    check("t1_prime_valid", 32'(nif.note_valid), 32'd0);
    tick_with(8'd168);
    check("t1_run", 32'(state), 32'd2);
    check("t1_cnt2", 32'(fifo_count), 32'd2);
    check("t1_valid", 32'(nif.note_valid), 32'd1);
    check("t1_lane0", 32'(nif.note_lane), 32'd0);
    check("t1_x0", 32'(nif.note_x), 32'd160);
    check("t1_idx0", 32'(nif.note_idx), 32'd0);
    nif.note_ready = 1'b1;
    data           = 8'd172;
    step();
    check("t1_lane1", 32'(nif.note_lane), 32'd2);
    check("t1_x1", 32'(nif.note_x), 32'd168);
    check("t1_idx1", 32'(nif.note_idx), 32'd1);
    step();
    check("t1_empty_valid", 32'(nif.note_valid), 32'd0);
    check("t1_empty_x", 32'(nif.note_x), 32'd0);
    check("t1_empty_idx", 32'(nif.note_idx), 32'd2);
    nif.note_ready = 1'b0;
    step(2);
    check("t1_lat_valid", 32'(nif.note_valid), 32'd1);
    check("t1_lat_x", 32'(nif.note_x), 32'd172);
    check("t1_lat_lane", 32'(nif.note_lane), 32'd3);
    to_idle();

    // 2: invalid samples
    data_en = 1'b1;
    data    = 8'd150;
    do_start();
    step(4);
    tick_with(8'd162);
    tick_with(8'd180);
    check("t2_bad", 32'(bad_data), 32'd1);
    check("t2_cnt", 32'(fifo_count), 32'd0);
    check("t2_state", 32'(state), 32'd1);
    to_idle();
    probe(8'd159, 1'b1, 3'd0);
    probe(8'd162, 1'b1, 3'd0);
    probe(8'd180, 1'b1, 3'd0);
    probe(8'd176, 1'b0, 3'd1);
    probe(8'd160, 1'b0, 3'd1);

    // 3: overflow with stalled consumer
    data_en        = 1'b1;
    nif.note_ready = 1'b0;
    do_start();
    check("t3_clr_bad", 32'(bad_data), 32'd0);
    tick_with(8'd160);
    tick_with(8'd164);
    tick_with(8'd168);
    tick_with(8'd172);
    check("t3_full_cnt", 32'(fifo_count), 32'd4);
    check("t3_full_ovf", 32'(overflow), 32'd0);
    tick_with(8'd176);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_cnt", 32'(fifo_count), 32'd4);
    tick_with(8'd160);
    check("t3_cnt_b", 32'(fifo_count), 32'd4);
    data_en        = 1'b0;
    nif.note_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_x%0d", i), 32'(nif.note_x), 32'(160 + 4 * i));
      check($sformatf("t3_lane%0d", i), 32'(nif.note_lane), 32'(i));
      check($sformatf("t3_idx%0d", i), 32'(nif.note_idx), 32'(i));
      step();
    end
    check("t3_drained", 32'(fifo_count), 32'd0);
    to_idle();

    // 4: stop coinciding with a tick, drain, then idle ignores ticks
    data_en        = 1'b1;
    nif.note_ready = 1'b0;
    do_start();
    tick_with(8'd160);
    tick_with(8'd164);
    tick_with(8'd168);
    data = 8'd172;
    step(3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_drain", 32'(state), 32'd3);
    check("t4_cnt", 32'(fifo_count), 32'd3);
    nif.note_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_valid%0d", i), 32'(nif.note_valid), 32'd1);
      check($sformatf("t4_x%0d", i), 32'(nif.note_x), 32'(160 + 4 * i));
      step();
    end
    check("t4_cnt0", 32'(fifo_count), 32'd0);
    step();
    check("t4_idle", 32'(state), 32'd0);
    check("t4_idle_valid", 32'(nif.note_valid), 32'd0);
    data = 8'd160;
    step(8);
    check("t4_idle_nopush", 32'(fifo_count), 32'd0);
    check("t4_idle_state", 32'(state), 32'd0);
    nif.note_ready = 1'b0;

    // 5: simultaneous push/pop, index wrap and pointer wrap
    data_en = 1'b1;
    do_start();
    tick_with(8'd160);
    tick_with(8'd164);
    data = 8'd168;
    step(3);
    nif.note_ready = 1'b1;
    step();
    check("t5_pushpop_cnt", 32'(fifo_count), 32'd2);
    check("t5_pushpop_x", 32'(nif.note_x), 32'd164);
    check("t5_pushpop_idx", 32'(nif.note_idx), 32'd1);
    exp_q.delete();
    exp_q.push_back(8'd164);
    exp_q.push_back(8'd168);
    exp_idx = 8'd1;
    for (int i = 0; i < 300; i++) begin
      data = 8'(160 + 4 * (i % 5));
      exp_q.push_back(data);
      for (int c = 0; c < 4; c++) begin
        if (nif.note_valid) pop_check();
        step();
      end
    end
    data_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (nif.note_valid) pop_check();
      step();
    end
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t5_idx_wrap", 32'(nif.note_idx), 32'd47);
    check("t5_cnt", 32'(fifo_count), 32'd0);
    to_idle();

    // 6: asynchronous reset mid-RUN
    data_en        = 1'b1;
    nif.note_ready = 1'b0;
    do_start();
    tick_with(8'd150);
    tick_with(8'd160);
    tick_with(8'd164);
    check("t6_run", 32'(state), 32'd2);
    check("t6_bad_pre", 32'(bad_data), 32'd1);
    nif.note_ready = 1'b1;
    step();
    check("t6_idx_pre", 32'(nif.note_idx), 32'd1);
    nif.note_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_cnt", 32'(fifo_count), 32'd0);
    check("t6_valid", 32'(nif.note_valid), 32'd0);
    check("t6_idx", 32'(nif.note_idx), 32'd0);
    check("t6_x", 32'(nif.note_x), 32'd0);
    check("t6_bad", 32'(bad_data), 32'd0);
    step(2);
    resetn = 1'b1;
    step();

    // Repeated lane: collapsed only when dedup is built in
    data_en = 1'b1;
    do_start();
    tick_with(8'd164);
    tick_with(8'd164);
    tick_with(8'd172);
`ifdef BEAT_DEDUP_EN
    check("t6_dedup_cnt", 32'(fifo_count), 32'd2);
`else
    check("t6_dedup_cnt", 32'(fifo_count), 32'd3);
`endif
    check("t6_dedup_bad", 32'(bad_data), 32'd0);
    check("t6_dedup_ovf", 32'(overflow), 32'd0);
    to_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
